lsu_mem_ctrl: RTL and testbench

Load/store sequencer between the core's memory stage and the byte-wide, byte-addressable data memory. It accepts one RV32 load or store per handshake and serialises it into 1, 2 or 4 single-byte memory accesses, little-endian (lowest address = LSB). It assembles read bytes and sign- or zero-extends them per funct3, and rejects illegal, misaligned or out-of-range accesses with an error response.

---
 rtl/lsu_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: serialises one RV32 load/store into 1/2/4 little-endian
// byte accesses on a byte-wide memory and returns an extended load result.
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 2048,
  parameter int MISALIGN_OK = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [2:0]                   req_funct3,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [ADDR_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [ADDR_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic                         mem_r_en,
  output logic                         mem_wr_en,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata
);

  localparam int MA_W = $clog2(MEM_BYTES);
  localparam int AW1  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [2:0]          f3_reg;
  logic [MA_W-1:0]     addr_reg;
  logic [ADDR_W-1:0]   wdata_reg;
  logic [ADDR_W-1:0]   rdata_reg;
  logic [2:0]          nbytes_reg;
  logic [1:0]          k_reg;
  logic                err_reg;

  logic                hs;
  logic [2:0]          req_nbytes;
  logic [1:0]          req_mask;
  logic                f3_ok;
  logic                misal;
  logic                oor;
  logic                req_err;
  logic [AW1-1:0]      req_last;
  logic [1:0]          k_last;
  logic [1:0]          k_prev;

  assign hs     = req_valid && req_ready;
  assign k_last = 2'(nbytes_reg - 3'd1);
  assign k_prev = k_reg - 2'd1;

  // Request decode: size, legality, alignment and range (range at ADDR_W+1 bits so it cannot wrap)
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
      default:                                f3_ok = 1'b0;
    endcase
    req_mask = 2'(req_nbytes - 3'd1);
    misal    = (MISALIGN_OK == 0) && (|(req_addr[1:0] & req_mask));
    req_last = {1'b0, req_addr} + AW1'(req_nbytes) - AW1'(1);
    oor      = (req_last >= AW1'(MEM_BYTES));
    req_err  = !f3_ok || (req_we && req_funct3[2]) || misal || oor;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hs) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (k_reg == k_last) state_next = we_reg ? RESP : DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load bytes arrive one cycle after their strobe, so byte k-1 is captured while byte k is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg     <= 1'b0;
      f3_reg     <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      nbytes_reg <= 3'd0;
      k_reg      <= 2'd0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hs) begin
            we_reg     <= req_we;
            f3_reg     <= req_funct3;
            addr_reg   <= req_addr[MA_W-1:0];
            wdata_reg  <= req_wdata;
            nbytes_reg <= req_nbytes;
            err_reg    <= req_err;
            rdata_reg  <= '0;
            k_reg      <= 2'd0;
          end
        end
        ACCESS: begin
          k_reg <= k_reg + 2'd1;
          if (!we_reg && (k_reg != 2'd0))
            rdata_reg[{k_prev, 3'b000} +: 8] <= mem_rdata;
        end
        DRAIN: rdata_reg[{k_last, 3'b000} +: 8] <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst so an aborted request issues nothing in the reset cycle
  always_comb begin
    req_ready  = (state_reg == IDLE);
    mem_r_en   = (state_reg == ACCESS) && !we_reg && !rst;
    mem_wr_en  = (state_reg == ACCESS) && we_reg && !rst;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    if (state_reg == ACCESS) begin
      mem_addr = addr_reg + MA_W'(k_reg);
      if (we_reg) mem_wdata = wdata_reg[{k_reg, 3'b000} +: 8];
    end
    resp_valid = (state_reg == RESP);
    resp_err   = (state_reg == RESP) && err_reg;
    resp_rdata = '0;
    if ((state_reg == RESP) && !err_reg && !we_reg) begin
      case (f3_reg)
        3'b000:  resp_rdata = {{(ADDR_W-8){rdata_reg[7]}}, rdata_reg[7:0]};
        3'b001:  resp_rdata = {{(ADDR_W-16){rdata_reg[15]}}, rdata_reg[15:0]};
        3'b100:  resp_rdata = {{(ADDR_W-8){1'b0}}, rdata_reg[7:0]};
        3'b101:  resp_rdata = {{(ADDR_W-16){1'b0}}, rdata_reg[15:0]};
        default: resp_rdata = rdata_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a strict-alignment and a misalign-tolerant
// instance, each with its own byte memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid0, valid1;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        ready0, rv0, err0, re0, we0;
  logic [31:0] rd0;
  logic [10:0] ma0;
  logic [7:0]  wd0, mrd0;
  logic        ready1, rv1, err1, re1, we1;
  logic [31:0] rd1;
  logic [10:0] ma1;
  logic [7:0]  wd1, mrd1;

  logic [7:0]  mem0 [0:2047];
  logic [7:0]  mem1 [0:2047];
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [7:0]  pl_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_r [1:12];
  logic        s_w [1:12];
  logic [10:0] s_a [1:12];
  logic [7:0]  s_d [1:12];
  int          resp_n;
  int          n_strb;
  int          n_both;
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(2048), .MISALIGN_OK(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .mem_addr(ma0),
    .mem_r_en(re0), .mem_wr_en(we0), .mem_wdata(wd0), .mem_rdata(mrd0));

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(2048), .MISALIGN_OK(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .mem_addr(ma1),
    .mem_r_en(re1), .mem_wr_en(we1), .mem_wdata(wd1), .mem_rdata(mrd1));

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end
    if (we0) mem0[ma0] <= wd0;
    if (re0) mrd0 <= mem0[ma0];
    if (we1) mem1[ma1] <= wd1;
    if (re1) mrd1 <= mem1[ma1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request at a falling edge (cycle T) and log cycles T+1.. until the response
  task automatic txn(input bit sel, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    chk("req_ready", 32'(sel ? ready1 : ready0), 32'd1);
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0;
    resp_n = 0; n_strb = 0; n_both = 0; r_data = 32'hx; r_err = 1'bx;
    for (int n = 1; n <= 12 && resp_n == 0; n++) begin
      s_r[n] = sel ? re1 : re0;
      s_w[n] = sel ? we1 : we0;
      s_a[n] = sel ? ma1 : ma0;
      s_d[n] = sel ? wd1 : wd0;
      if (s_r[n] || s_w[n]) n_strb++;
      if (s_r[n] && s_w[n]) n_both++;
      if (sel ? rv1 : rv0) begin
        resp_n = n;
        r_data = sel ? rd1 : rd0;
        r_err  = sel ? err1 : err0;
      end
      @(negedge clk);
    end
    $display("txn dut%0d we=%0d f3=%03b addr=%h wdata=%h -> resp@T+%0d err=%0b rdata=%h strobes=%0d",
             sel, we, f3, addr, wd, resp_n, r_err, r_data, n_strb);
    chk("strobe_excl", 32'(n_both), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_addr = 11'h0; pl_data = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_resp_valid", 32'(rv0), 32'd0);
    chk("rst_resp_err", 32'(err0), 32'd0);
    chk("rst_resp_rdata", rd0, 32'd0);
    chk("rst_strobes", 32'({re0, we0}), 32'd0);
    chk("rst_mem_addr", 32'(ma0), 32'd0);
    chk("rst_mem_wdata", 32'(wd0), 32'd0);
    rst = 1'b0;

    preload(11'h10, 8'h78); preload(11'h11, 8'h56);
    preload(11'h12, 8'h34); preload(11'h13, 8'h12);
    preload(11'h14, 8'h9A);
    for (int i = 0; i < 4; i++) preload(11'(32'h40 + i), 8'h00);

    // LW 0x10
    txn(0, 0, 3'b010, 32'h10, 32'h0);
    for (int n = 1; n <= 4; n++) begin
      chk("lw_rd_en", 32'(s_r[n]), 32'd1);
      chk("lw_rd_addr", 32'(s_a[n]), 32'h10 + 32'(n - 1));
    end
    chk("lw_drain_quiet", 32'(s_r[5] | s_w[5]), 32'd0);
    chk("lw_latency", 32'(resp_n), 32'd6);
    chk("lw_rdata", r_data, 32'h12345678);
    chk("lw_err", 32'(r_err), 32'd0);

    preload(11'h13, 8'h80);
    txn(0, 0, 3'b000, 32'h13, 32'h0);
    chk("lb_latency", 32'(resp_n), 32'd3);
    chk("lb_rdata", r_data, 32'hFFFFFF80);
    txn(0, 0, 3'b100, 32'h13, 32'h0);
    chk("lbu_rdata", r_data, 32'h00000080);
    txn(0, 0, 3'b001, 32'h12, 32'h0);
    chk("lh_latency", 32'(resp_n), 32'd4);
    chk("lh_rdata", r_data, 32'hFFFF8034);

    // SH 0x22 then read back
    txn(0, 1, 3'b001, 32'h22, 32'hAABBCCDD);
    chk("sh_w1", {s_w[1], 3'b0, s_a[1], s_d[1]}, {1'b1, 3'b0, 11'h22, 8'hDD});
    chk("sh_w2", {s_w[2], 3'b0, s_a[2], s_d[2]}, {1'b1, 3'b0, 11'h23, 8'hCC});
    chk("sh_latency", 32'(resp_n), 32'd3);
    chk("sh_rdata", r_data, 32'd0);
    txn(0, 0, 3'b101, 32'h22, 32'h0);
    chk("lhu_rdata", r_data, 32'h0000CCDD);

    // Misaligned word: strict instance errors, tolerant instance reads 0x11..0x14
    txn(0, 0, 3'b010, 32'h11, 32'h0);
    chk("mis_err_latency", 32'(resp_n), 32'd1);
    chk("mis_err", 32'(r_err), 32'd1);
    chk("mis_err_rdata", r_data, 32'd0);
    chk("mis_err_strobes", 32'(n_strb), 32'd0);
    txn(1, 0, 3'b010, 32'h11, 32'h0);
    for (int n = 1; n <= 4; n++) chk("mis_ok_addr", 32'(s_a[n]), 32'h11 + 32'(n - 1));
    chk("mis_ok_latency", 32'(resp_n), 32'd6);
    chk("mis_ok_rdata", r_data, 32'h9A803456);
    chk("mis_ok_err", 32'(r_err), 32'd0);

    // Range and encoding errors
    txn(0, 0, 3'b010, 32'h7FE, 32'h0);
    chk("oor_err", {31'(resp_n), r_err}, {31'd1, 1'b1});
    chk("oor_strobes", 32'(n_strb), 32'd0);
    txn(1, 0, 3'b010, 32'h7FE, 32'h0);
    chk("oor_mis_ok_err", {31'(resp_n), r_err}, {31'd1, 1'b1});
    txn(0, 0, 3'b011, 32'h20, 32'h0);
    chk("f3_011_err", {31'(resp_n), r_err}, {31'd1, 1'b1});
    txn(0, 1, 3'b100, 32'h20, 32'h55);
    chk("sbu_err", {31'(resp_n), r_err}, {31'd1, 1'b1});
    chk("sbu_strobes", 32'(n_strb), 32'd0);
    txn(0, 0, 3'b010, 32'h7FC, 32'h0);
    chk("lw_top_ok_err", {31'(resp_n), r_err}, {31'd6, 1'b0});

    // SW 0x40 aborted by reset in cycle T+3
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h11223344;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    chk("abort_w1", {we0, 3'b0, ma0, wd0}, {1'b1, 3'b0, 11'h40, 8'h44});
    @(negedge clk);
    chk("abort_w2", {we0, 3'b0, ma0, wd0}, {1'b1, 3'b0, 11'h41, 8'h33});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_strobe", 32'(we0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready0), 32'd1);
    for (int n = 0; n < 4; n++) begin
      chk("abort_no_resp", 32'({rv0, we0, re0}), 32'd0);
      @(negedge clk);
    end
    $display("txn dut0 SW 0x40 aborted by rst: mem[40..43]=%h %h %h %h",
             mem0[11'h40], mem0[11'h41], mem0[11'h42], mem0[11'h43]);
    chk("abort_mem", {mem0[11'h43], mem0[11'h42], mem0[11'h41], mem0[11'h40]}, 32'h00003344);

    txn(0, 0, 3'b010, 32'h10, 32'h0);
    chk("post_rst_lw_latency", 32'(resp_n), 32'd6);
    chk("post_rst_lw_rdata", r_data, 32'h80345678);
    // Back-to-back: next request accepted immediately after the RESP cycle
    txn(0, 0, 3'b100, 32'h10, 32'h0);
    chk("b2b_lbu_rdata", r_data, 32'h00000078);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
